// File: rtl/cmd_frame_decoder.sv
// ---------------------------------------------------------------------------
// cmd_frame_decoder
//
// Receive-side command parser. Reassembles host command frames from the UART
// received-byte strobe:
//   0x55, cmd, axis, param, d0, d1, d2, d3, [chk], 0xAA
// d0 is the most significant data byte. One decoded command is presented per
// good frame. Framing, timeout and axis errors are reported. A one-byte
// ACK/NAK reply is queued for the UART transmitter via valid/ready.
//
// Optional feature macro: CMD_FRAME_CHECKSUM_EN
//   defined   -> a checksum byte (XOR of cmd, axis, param, d0..d3) precedes
//                the tail; a mismatch rejects the frame with err_code 1.
//   undefined -> no checksum byte; frames are exactly 9 bytes.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx_data    received byte, valid while rx_valid = 1
//   rx_valid   one-cycle strobe per received byte
//   cmd_valid  one-cycle pulse: good frame decoded
//   cmd_code   command byte of last good frame
//   cmd_axis   axis byte of last good frame
//   cmd_param  param byte of last good frame
//   cmd_data   data word of last good frame (first data byte in [31:24])
//   frame_err  one-cycle pulse: frame rejected
//   err_code   last rejection reason: 1 tail/checksum, 2 timeout, 3 bad axis
//   busy       high while a frame is in progress
//   ack_valid  reply byte pending
//   ack_byte   reply byte: 0x06 ACK, 0x15 NAK
//   ack_ready  transmitter accepts ack_byte
// ---------------------------------------------------------------------------
module cmd_frame_decoder #(
  parameter logic [31:0] CLK_FREQ   = 32'd40_000_000,
  parameter logic [31:0] TIMEOUT_US = 32'd1000,
  parameter logic [7:0]  NUM_AXES   = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [7:0]  cmd_axis,
  output logic [7:0]  cmd_param,
  output logic [31:0] cmd_data,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic        ack_valid,
  output logic [7:0]  ack_byte,
  input  logic        ack_ready
);

  localparam logic [31:0] TIMEOUT_CYCLES = CLK_FREQ / 32'd1_000_000 * TIMEOUT_US;

  localparam logic [7:0] HDR_BYTE  = 8'h55;
  localparam logic [7:0] TAIL_BYTE = 8'hAA;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam logic [1:0] ERR_FRAME   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_AXIS    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_AXIS, S_PARAM, S_DATA, S_CHK, S_TAIL
  } state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] to_cnt;
  logic [7:0]  sh_code;
  logic [7:0]  sh_axis;
  logic [7:0]  sh_param;
  logic [31:0] sh_data;
  logic        axis_ok;
  logic        chk_bad;

`ifdef CMD_FRAME_CHECKSUM_EN
  logic [7:0]  chk_acc;
`else
  assign chk_bad = 1'b0;
`endif

  assign axis_ok = (sh_axis != 8'd0) && (sh_axis <= NUM_AXES);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: shadow registers are reset too, so a reset mid-frame leaves no
      // stale partial frame behind; they are few flops, not a memory array.
      state     <= S_IDLE;
      byte_idx  <= 2'd0;
      to_cnt    <= 32'd0;
      sh_code   <= 8'd0;
      sh_axis   <= 8'd0;
      sh_param  <= 8'd0;
      sh_data   <= 32'd0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'd0;
      cmd_axis  <= 8'd0;
      cmd_param <= 8'd0;
      cmd_data  <= 32'd0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      ack_valid <= 1'b0;
      ack_byte  <= 8'd0;
`ifdef CMD_FRAME_CHECKSUM_EN
      chk_acc   <= 8'd0;
      chk_bad   <= 1'b0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;

      // NOTE: non-blocking assignments here; a later assignment in this block
      // to ack_valid (frame completion) overrides this clear, so a new reply
      // arriving in the acceptance cycle wins.
      if (ack_valid && ack_ready) ack_valid <= 1'b0;

      if (state == S_IDLE) begin
        to_cnt <= 32'd0;
        if (rx_valid && rx_data == HDR_BYTE) state <= S_CMD;
      end else if (rx_valid) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        to_cnt <= 32'd0;
        case (state)
          S_CMD: begin
            sh_code <= rx_data;
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_acc <= rx_data;
`endif
            state   <= S_AXIS;
          end
          S_AXIS: begin
            sh_axis <= rx_data;
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_acc <= chk_acc ^ rx_data;
`endif
            state   <= S_PARAM;
          end
          S_PARAM: begin
            sh_param <= rx_data;
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_acc  <= chk_acc ^ rx_data;
`endif
            byte_idx <= 2'd0;
            state    <= S_DATA;
          end
          S_DATA: begin
            sh_data  <= {sh_data[23:0], rx_data};
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_acc  <= chk_acc ^ rx_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
`ifdef CMD_FRAME_CHECKSUM_EN
              state <= S_CHK;
`else
              state <= S_TAIL;
`endif
            end
          end
          S_CHK: begin
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_bad <= (rx_data != chk_acc);
`endif
            state <= S_TAIL;
          end
          S_TAIL: begin
            if (chk_bad || rx_data != TAIL_BYTE) begin
              frame_err <= 1'b1;
              err_code  <= ERR_FRAME;
              ack_byte  <= NAK_BYTE;
            end else if (!axis_ok) begin
              frame_err <= 1'b1;
              err_code  <= ERR_AXIS;
              ack_byte  <= NAK_BYTE;
            end else begin
              cmd_valid <= 1'b1;
              cmd_code  <= sh_code;
              cmd_axis  <= sh_axis;
              cmd_param <= sh_param;
              cmd_data  <= sh_data;
              ack_byte  <= ACK_BYTE;
            end
            ack_valid <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (to_cnt == TIMEOUT_CYCLES - 32'd1) begin
        // This clock is the TIMEOUT_CYCLES-th idle clock since the last byte.
        to_cnt    <= 32'd0;
        frame_err <= 1'b1;
        err_code  <= ERR_TIMEOUT;
        state     <= S_IDLE;
      end else begin
        to_cnt <= to_cnt + 32'd1;
      end
    end
  end

endmodule
